// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and lane helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACC0,
      ST_ACC1
   } state_t;

   function automatic logic [2:0] byte_cnt(input logic [1:0] size);
      logic [2:0] n;
      case (size)
         SZ_B:    n = 3'd1;
         SZ_H:    n = 3'd2;
         SZ_W:    n = 3'd4;
         default: n = 3'd0;
      endcase
      return n;
   endfunction

   // Enables span two words: [3:0] first word, [7:4] following word.
   function automatic logic [7:0] byte_en(input logic [1:0] size,
                                          input logic [1:0] off);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'h00;
      endcase
      return base << off;
   endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Combinational byte-lane rotate/merge for stores and
// lane assembly plus sign/zero extension for loads.
module lsu_lane_align
   import dmem_lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        uns,
   input  logic        hi,
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [31:0] word0,
   input  logic [31:0] word1,
   output logic [31:0] st_word,
   output logic [31:0] ld_data
);

   logic [7:0]  be;
   logic [63:0] sdat;
   logic [3:0]  lane_be;
   logic [31:0] lane_d;
   logic [63:0] ldw;

   always_comb begin
      be      = byte_en(size, off);
      sdat    = {32'b0, wdata} << {off, 3'b000};
      lane_be = hi ? be[7:4] : be[3:0];
      lane_d  = hi ? sdat[63:32] : sdat[31:0];
      st_word = old_word;
      for (int i = 0; i < 4; i++) begin
         if (lane_be[i]) st_word[8*i +: 8] = lane_d[8*i +: 8];
      end
   end

   always_comb begin
      ldw = {word1, word0} >> {off, 3'b000};
      unique case (size)
         SZ_B:    ld_data = {{24{~uns & ldw[7]}}, ldw[7:0]};
         SZ_H:    ld_data = {{16{~uns & ldw[15]}}, ldw[15:0]};
         default: ld_data = ldw[31:0];
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for a word-only data memory.
// MISALIGN_TRAP_EN: misaligned half/word requests return an error.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int MEM_DEPTH = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   state_t      state;
   state_t      next;
   logic        acc;
   logic        last;
   logic        c_err;
   logic        c_cross;
   logic [30:0] idx0;

   logic        r_we;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_err;
   logic        r_cross;
   logic [31:0] word0_q;

   logic        hi;
   logic [31:0] lw0;
   logic [31:0] lw1;
   logic [31:0] st_word;
   logic [31:0] ld_data;

   assign acc  = req_valid && req_ready;
   assign idx0 = {1'b0, req_addr[31:2]};

`ifdef MISALIGN_TRAP_EN
   logic mis;
   always_comb begin
      mis = ((req_size == SZ_H) && req_addr[0])
         || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
      c_cross = 1'b0;
      c_err   = (req_size == SZ_X) || mis
             || (idx0 > 31'(MEM_DEPTH));
   end
`else
   logic [30:0] idx1;
   always_comb begin
      idx1    = idx0 + 31'd1;
      c_cross = (req_size != SZ_X)
             && (({1'b0, req_addr[1:0]} + byte_cnt(req_size)) > 3'd4);
      c_err   = (req_size == SZ_X)
             || (idx0 > 31'(MEM_DEPTH))
             || (c_cross && (idx1 > 31'(MEM_DEPTH)));
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         ST_IDLE: if (acc) next = ST_ACC0;
`ifdef MISALIGN_TRAP_EN
         ST_ACC0: next = ST_IDLE;
`else
         ST_ACC0: next = r_cross ? ST_ACC1 : ST_IDLE;
`endif
         default: next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      mem_a     = 32'b0;
      mem_wd    = 32'b0;
      mem_we    = 1'b0;
      hi        = 1'b0;
      last      = 1'b0;
      case (state)
         ST_IDLE: req_ready = 1'b1;
         ST_ACC0: begin
            mem_a  = {r_addr[31:2], 2'b00};
            mem_wd = st_word;
            mem_we = r_we && !r_err;
            last   = !r_cross;
         end
`ifndef MISALIGN_TRAP_EN
         ST_ACC1: begin
            mem_a  = {r_addr[31:2] + 30'd1, 2'b00};
            mem_wd = st_word;
            mem_we = r_we;
            hi     = 1'b1;
            last   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // In ACC1 the first word comes from the capture register.
   assign lw0 = hi ? word0_q : mem_rd;
   assign lw1 = hi ? mem_rd : 32'b0;

   lsu_lane_align u_align (
      .size     (r_size),
      .off      (r_addr[1:0]),
      .uns      (r_uns),
      .hi       (hi),
      .old_word (mem_rd),
      .wdata    (r_wdata),
      .word0    (lw0),
      .word1    (lw1),
      .st_word  (st_word),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we       <= 1'b0;
         r_size     <= SZ_B;
         r_uns      <= 1'b0;
         r_addr     <= 32'b0;
         r_wdata    <= 32'b0;
         r_err      <= 1'b0;
         r_cross    <= 1'b0;
         word0_q    <= 32'b0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'b0;
      end else begin
         if (acc) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= c_err;
            r_cross <= c_cross && !c_err;
         end
         if (state == ST_ACC0) word0_q <= mem_rd;
         resp_valid <= last;
         resp_err   <= last && r_err;
         resp_rdata <= (last && !r_we && !r_err) ? ld_data : 32'b0;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a word memory model.
// Expectations follow MISALIGN_TRAP_EN when it is defined.
module tb_dmem_lsu;
   import dmem_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:127];
   logic        clr;
   logic        pre_en;
   logic [6:0]  pre_idx;
   logic [31:0] pre_val;

   int errors = 0;
   int checks = 0;
   int we_cnt = 0;
   int rv_cnt = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.MEM_DEPTH(63)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_a        (mem_a),
      .mem_wd       (mem_wd),
      .mem_we       (mem_we),
      .mem_rd       (mem_rd)
   );

   assign mem_rd = mem[mem_a[8:2]];

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 128; i++) mem[i] <= 32'b0;
      end else if (pre_en) begin
         mem[pre_idx] <= pre_val;
      end else if (mem_we) begin
         mem[mem_a[8:2]] <= mem_wd;
      end
   end

   always @(negedge clk) begin
      if (mem_we) we_cnt++;
      if (resp_valid) rv_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preset(input int idx, input logic [31:0] val);
      @(negedge clk);
      pre_en  = 1'b1;
      pre_idx = 7'(idx);
      pre_val = val;
      @(negedge clk);
      pre_en  = 1'b0;
   endtask

   task automatic xfer(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic er);
      int n;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = wd;
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      n = 0;
      while (n < 10) begin
         @(posedge clk);
         #1;
         lat++;
         if (resp_valid) break;
         n++;
      end
      if (!resp_valid) lat = 99;
      rd = resp_rdata;
      er = resp_err;
   endtask

   initial begin
      int lat;
      logic [31:0] rd;
      logic er;
      int w0;
      int r0;
      int n;

      rst          = 1'b0;
      clr          = 1'b1;
      pre_en       = 1'b0;
      pre_idx      = 7'd0;
      pre_val      = 32'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = SZ_B;
      req_unsigned = 1'b0;
      req_addr     = 32'b0;
      req_wdata    = 32'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rvalid", {31'b0, resp_valid}, 32'd0);
      chk("rst_rerr", {31'b0, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_we", {31'b0, mem_we}, 32'd0);
      chk("rst_a", mem_a, 32'd0);
      chk("rst_wd", mem_wd, 32'd0);
      @(negedge clk);
      clr = 1'b0;
      rst = 1'b1;

      preset(1, 32'h8899AABB);
      preset(2, 32'h11223344);
      preset(3, 32'hDDCCBBAA);
      preset(4, 32'h44332211);
      preset(63, 32'h0BADF00D);

      xfer(1'b0, SZ_B, 1'b0, 32'h6, 32'h0, lat, rd, er);
      chk("lb_data", rd, 32'hFFFFFF99);
      chk("lb_lat", lat, 32'd2);
      chk("lb_err", {31'b0, er}, 32'd0);
      xfer(1'b0, SZ_B, 1'b1, 32'h6, 32'h0, lat, rd, er);
      chk("lbu_data", rd, 32'h00000099);
      xfer(1'b0, SZ_H, 1'b0, 32'hE, 32'h0, lat, rd, er);
      chk("lh_data", rd, 32'hFFFFDDCC);
      xfer(1'b0, SZ_W, 1'b0, 32'h4, 32'h0, lat, rd, er);
      chk("lw_aligned", rd, 32'h8899AABB);

      w0 = we_cnt;
      xfer(1'b1, SZ_H, 1'b0, 32'h9, 32'hBEEF, lat, rd, er);
`ifdef MISALIGN_TRAP_EN
      chk("sh_err", {31'b0, er}, 32'd1);
      chk("sh_mem", mem[2], 32'h11223344);
      chk("sh_we_cnt", we_cnt - w0, 32'd0);
`else
      chk("sh_err", {31'b0, er}, 32'd0);
      chk("sh_mem", mem[2], 32'h11BEEF44);
      chk("sh_we_cnt", we_cnt - w0, 32'd1);
      chk("sh_lat", lat, 32'd2);
`endif
      chk("sh_rdata", rd, 32'd0);

      xfer(1'b0, SZ_W, 1'b0, 32'hF, 32'h0, lat, rd, er);
`ifdef MISALIGN_TRAP_EN
      chk("lw_x_err", {31'b0, er}, 32'd1);
      chk("lw_x_data", rd, 32'd0);
`else
      chk("lw_x_err", {31'b0, er}, 32'd0);
      chk("lw_x_data", rd, 32'h332211DD);
      chk("lw_x_lat", lat, 32'd3);
`endif

      w0 = we_cnt;
      xfer(1'b1, SZ_W, 1'b0, 32'h11, 32'hCAFEBABE, lat, rd, er);
`ifdef MISALIGN_TRAP_EN
      chk("sw_x_m4", mem[4], 32'h44332211);
      chk("sw_x_we", we_cnt - w0, 32'd0);
`else
      chk("sw_x_m4", mem[4], 32'hFEBABE11);
      chk("sw_x_m5", mem[5], 32'h000000CA);
      chk("sw_x_we", we_cnt - w0, 32'd2);
`endif

      w0 = we_cnt;
      xfer(1'b1, SZ_W, 1'b0, 32'hFD, 32'hCAFEBABE, lat, rd, er);
      chk("oob_err", {31'b0, er}, 32'd1);
      chk("oob_rdata", rd, 32'd0);
      chk("oob_m63", mem[63], 32'h0BADF00D);
      chk("oob_we", we_cnt - w0, 32'd0);
      xfer(1'b0, SZ_W, 1'b0, 32'hFC, 32'h0, lat, rd, er);
      chk("top_word_err", {31'b0, er}, 32'd0);
      chk("top_word_data", rd, 32'h0BADF00D);
      xfer(1'b0, SZ_W, 1'b0, 32'h100, 32'h0, lat, rd, er);
      chk("oob_load_err", {31'b0, er}, 32'd1);
      xfer(1'b0, SZ_X, 1'b0, 32'h4, 32'h0, lat, rd, er);
      chk("sz11_err", {31'b0, er}, 32'd1);
      chk("sz11_rdata", rd, 32'd0);

      preset(9, 32'h55555555);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = SZ_W;
      req_addr  = 32'h21;
      req_wdata = 32'h12345678;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rstmid_we", {31'b0, mem_we}, 32'd0);
      chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      chk("rstmid_m9", mem[9], 32'h55555555);

      for (int k = 16; k < 20; k++) preset(k, 32'h0);
      w0 = we_cnt;
      r0 = rv_cnt;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_size  = SZ_W;
         req_addr  = 32'(64 + 4 * k);
         req_wdata = 32'hA0000000 + 32'(k);
         n = 0;
         while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
         end
         chk("b2b_ready", {31'b0, req_ready}, 32'd1);
         @(posedge clk);
      end
      #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("b2b_resp_cnt", rv_cnt - r0, 32'd4);
      chk("b2b_we_cnt", we_cnt - w0, 32'd4);
      for (int k = 0; k < 4; k++)
         chk("b2b_mem", mem[16 + k], 32'hA0000000 + 32'(k));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
